// File: rtl/stage3_types_pkg.sv
// Shared types for the fetch stage: fetch/execute packet layout, FSM encoding and the NOP word.
package stage3_types_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_BOOT    = 2'd0;
  localparam fetch_state_t ST_FETCH   = 2'd1;
  localparam fetch_state_t ST_DISCARD = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        prediction;
    logic [31:0] badaddr;
    logic        mal_insn;
    logic        fault_insn;
  } fetch_pkt_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/stage3_fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and the memory agent (slave).
interface stage3_fetch_stage_if;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_busy;
  logic [31:0] imem_rdata;
  logic        imem_fault;

  modport master (
    output imem_ren, imem_addr,
    input  imem_busy, imem_rdata, imem_fault
  );

  modport slave (
    input  imem_ren, imem_addr,
    output imem_busy, imem_rdata, imem_fault
  );
endinterface

// File: rtl/stage3_fetch_hold_buffer.sv
// One-entry skid register that catches a fetch packet completing while execute is stalled.
module stage3_fetch_hold_buffer
  import stage3_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       load,
  input  logic       consume,
  input  logic       clear,
  input  fetch_pkt_t load_pkt,
  output logic       full,
  output fetch_pkt_t pkt
);

  logic       full_reg;
  fetch_pkt_t pkt_reg;

  // clear wins over load so a redirect can never leave a stale packet behind
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      full_reg <= 1'b0;
      pkt_reg  <= '0;
    end else if (clear) begin
      full_reg <= 1'b0;
    end else if (load) begin
      full_reg <= 1'b1;
      pkt_reg  <= load_pkt;
    end else if (consume) begin
      full_reg <= 1'b0;
    end
  end

  assign full = full_reg;
  assign pkt  = pkt_reg;

endmodule

// File: rtl/stage3_fetch_stage.sv
// Fetch stage: owns the PC, issues instruction-memory reads and fills the fetch/execute register.
module stage3_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0200,
  parameter logic [31:0] NOP_INSTR = stage3_types_pkg::NOP_INSTR
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_addr,
  input  logic                         if_ex_stall,
  input  logic                         if_ex_flush,
  stage3_fetch_stage_if.master         imem,
  output logic                         fe_valid,
  output logic                         fe_prediction,
  output logic                         fe_mal_insn,
  output logic                         fe_fault_insn,
  output logic [31:0]                  fe_pc,
  output logic [31:0]                  fe_pc4,
  output logic [31:0]                  fe_instr,
  output logic [31:0]                  fe_badaddr
);

  import stage3_types_pkg::*;

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  discard_addr_reg;
  fetch_pkt_t   fe_reg, fe_next;
  fetch_pkt_t   new_pkt, buf_pkt;
  logic         buf_full, buf_load, buf_consume, buf_clear;
  logic         misaligned, outstanding, complete, mis_emit, pkt_valid;

  assign misaligned = (pc_reg[1:0] != 2'b00);

  // In DISCARD the bus still sees the abandoned address until the agent finishes with it
  assign imem.imem_ren  = (state_reg == ST_DISCARD) ||
                          ((state_reg == ST_FETCH) && !buf_full && !misaligned);
  assign imem.imem_addr = (state_reg == ST_DISCARD) ? discard_addr_reg : pc_reg;

  assign outstanding = imem.imem_ren && imem.imem_busy;
  assign complete    = (state_reg == ST_FETCH) && imem.imem_ren && !imem.imem_busy && !redirect;
  assign mis_emit    = (state_reg == ST_FETCH) && misaligned && !buf_full && !redirect;
  assign pkt_valid   = complete || mis_emit;

  always_comb begin
    new_pkt            = '0;
    new_pkt.valid      = 1'b1;
    new_pkt.pc         = pc_reg;
    new_pkt.pc4        = pc_plus4(pc_reg);
    new_pkt.instr      = imem.imem_rdata;
    new_pkt.prediction = 1'b0;
    if (misaligned) begin
      new_pkt.mal_insn = 1'b1;
      new_pkt.instr    = NOP_INSTR;
      new_pkt.badaddr  = pc_reg;
    end else if (imem.imem_fault) begin
      new_pkt.fault_insn = 1'b1;
      new_pkt.instr      = NOP_INSTR;
      new_pkt.badaddr    = pc_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_BOOT:    state_next = ST_FETCH;
      ST_FETCH:   if (redirect && outstanding) state_next = ST_DISCARD;
      ST_DISCARD: if (!imem.imem_busy) state_next = ST_FETCH;
      default:    state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    pc_next = pc_reg;
    if (redirect)
      pc_next = redirect_addr;
    else if (complete)
      pc_next = pc_plus4(pc_reg);
  end

  assign buf_load    = if_ex_stall && pkt_valid;
  assign buf_consume = !if_ex_stall && buf_full;
  assign buf_clear   = redirect || (!if_ex_stall && if_ex_flush);

  stage3_fetch_hold_buffer u_hold (
    .CLK      (CLK),
    .nRST     (nRST),
    .load     (buf_load),
    .consume  (buf_consume),
    .clear    (buf_clear),
    .load_pkt (new_pkt),
    .full     (buf_full),
    .pkt      (buf_pkt)
  );

  always_comb begin
    fe_next = fe_reg;
    if (!if_ex_stall) begin
      if (if_ex_flush)
        fe_next = '0;
      else if (buf_full)
        fe_next = buf_pkt;
      else if (pkt_valid)
        fe_next = new_pkt;
      else
        fe_next = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg        <= ST_BOOT;
      pc_reg           <= RESET_PC;
      discard_addr_reg <= RESET_PC;
      fe_reg           <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      fe_reg    <= fe_next;
      if ((state_reg == ST_FETCH) && redirect && outstanding)
        discard_addr_reg <= pc_reg;
    end
  end

  assign fe_valid      = fe_reg.valid;
  assign fe_pc         = fe_reg.pc;
  assign fe_pc4        = fe_reg.pc4;
  assign fe_instr      = fe_reg.instr;
  assign fe_prediction = fe_reg.prediction;
  assign fe_badaddr    = fe_reg.badaddr;
  assign fe_mal_insn   = fe_reg.mal_insn;
  assign fe_fault_insn = fe_reg.fault_insn;

endmodule

// File: doc/stage3_fetch_stage.md
Name: stage3_fetch_stage

Overview:
- First stage of the three-stage pipeline: owns the PC and issues instruction-memory reads.
- Fills the fetch/execute pipeline register consumed by the execute stage (valid, pc, pc4, instr, prediction, badaddr, mal_insn, fault_insn).
- Accepts redirects from the mem stage (branch mispredict, jump, exception, return).
- Tolerates redirects that arrive while a read is outstanding, and buffers one fetched instruction while execute is stalled.

Parameters:
- RESET_PC, 32'h0000_0200, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word placed in bubbles and exception slots.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- redirect  input  1  mem stage requests PC change this cycle
- redirect_addr  input  32  new PC target
- if_ex_stall  input  1  hazard unit: hold fetch/execute register
- if_ex_flush  input  1  hazard unit: squash fetch/execute register
- imem_busy  input  1  read not complete; rdata valid when low with imem_ren high
- imem_rdata  input  32  instruction word
- imem_fault  input  1  access fault, qualified like rdata
- imem_ren  output  1  read request
- imem_addr  output  32  read address
- fe_valid, fe_prediction, fe_mal_insn, fe_fault_insn  output  1 each  fetch/execute register bits
- fe_pc, fe_pc4, fe_instr, fe_badaddr  output  32 each  fetch/execute register words

Behaviour:
- Reset values:
  - pc = RESET_PC; FSM = BOOT; hold buffer empty; all fe_* = 0; imem_ren = 0.
  - imem_addr = RESET_PC.
  - Reset mid-transaction abandons the read; the bus agent must tolerate this.
- FSM states:
  - BOOT: one cycle with no request, then FETCH.
  - FETCH: imem_ren = 1 unless hold buffer full or pc misaligned; imem_addr = pc.
  - DISCARD: read outstanding when a redirect arrived; imem_ren = 1 with the original address held stable; the response is dropped.
- Bus rule: imem_addr must not change while imem_ren && imem_busy.
- Completion (FETCH, imem_ren && !imem_busy) produces a fetch packet:
  - valid = 1, pc, pc4 = pc + 4 (wraps mod 2^32), instr = imem_rdata, prediction = 0 (static not-taken).
  - fault_insn = imem_fault; if faulting, instr = NOP_INSTR and badaddr = pc.
  - pc advances to pc + 4 in the same edge.
- Misaligned PC (pc[1:0] != 0):
  - No bus request.
  - Packet produced immediately: valid = 1, mal_insn = 1, badaddr = pc, instr = NOP_INSTR.
  - pc does not advance; the stage waits for a redirect, re-emitting the packet each unstalled cycle.
- Register update on every edge:
  - !if_ex_stall && if_ex_flush: fe_* = 0.
  - !if_ex_stall && !if_ex_flush: fe_* = hold buffer if full (buffer empties), else the new packet this cycle, else a bubble (all 0).
  - if_ex_stall: fe_* retained. A packet completing this cycle goes to the one-entry hold buffer. While the buffer is full, no new request is issued.
- Redirect handling:
  - redirect: pc = redirect_addr, hold buffer cleared.
  - If a read is outstanding (imem_ren && imem_busy): go to DISCARD, keep the old address; on completion discard the data, go to FETCH and request redirect_addr next cycle.
  - A redirect in the same cycle as a completion discards that completion.
  - A redirect while in DISCARD overwrites the saved target.
  - Redirect has priority over the PC increment.
- Latency: with imem_busy = 0, an instruction at PC A appears in fe_* at the edge ending the request cycle; steady state is 1 instruction/cycle.
- The hazard unit asserts if_ex_flush together with redirect; this stage does not infer flush from redirect.

Decomposition:
- stage3_types_pkg: fetch packet struct (fields above), FSM state enum, NOP_INSTR constant.
- Natural sub-module: stage3_fetch_hold_buffer (one-entry skid register with full flag, load/consume/clear).
- PC/FSM logic and output register stay in the top module.

Test Plan:
- Reset release, imem_busy = 0, rdata = 32'h00A00093:
  - BOOT one cycle, then imem_addr = 0x200.
  - Next edge: fe_valid = 1, fe_pc = 0x200, fe_pc4 = 0x204, fe_instr = 0x00A00093.
- imem_busy high 3 cycles at 0x204:
  - imem_addr stays 0x204 throughout.
  - fe_valid = 0 bubbles, then fe_pc = 0x204.
- Redirect to 0x400 during busy read of 0x208:
  - Addr held at 0x208; its data never reaches fe_*.
  - Next request is 0x400; next valid packet fe_pc = 0x400.
- if_ex_stall for 2 cycles while 0x20C completes:
  - fe_* unchanged; no new request.
  - After release, fe_pc = 0x20C from the buffer, then 0x210.
- Redirect to 0x402:
  - No request issued.
  - fe_mal_insn = 1, fe_badaddr = 0x402, fe_instr = 0x00000013.
  - Redirect to 0x500 resumes normal fetch.
- imem_fault = 1 on completion at 0x300:
  - fe_fault_insn = 1, fe_badaddr = 0x300, fe_instr = NOP.
- Flush without stall: fe_* all zero.
- Stall + flush together: fe_* retained.
